// File: rtl/pipelined_adder.sv
// pipelined_adder: N-bit adder split into STAGES carry-rippled segments of
// W = N/STAGES bits, with valid/ready flow control and a registered output rank.
// A set accepted on edge t is presented on the outputs after edge t+STAGES.
// Optional feature macro: PIPELINED_ADDER_SUB_EN adds the i_sub port
// (i_sub=1 computes i_a + ~i_b + i_carry_in).
// N must be an integer multiple of STAGES.

module pipelined_adder #(
    parameter int N      = 64,
    parameter int STAGES = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_carry_in,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic         i_sub,
`endif
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_c,
    output logic         o_carry_out
);

    localparam int W = N / STAGES;

    logic         adv_s;
    logic [N-1:0] b_in_s;
    logic         o_valid_q;
    logic [N-1:0] o_c_q;
    logic         o_carry_out_q;

    // The whole pipe moves together unless a finished result is being held.
    assign adv_s   = !o_valid_q || i_ready;
    assign o_ready = adv_s;

    // Subtraction only inverts the second operand; the caller supplies the +1
    // through i_carry_in. The effective operand travels with its set.
`ifdef PIPELINED_ADDER_SUB_EN
    assign b_in_s = i_sub ? ~i_b : i_b;
`else
    assign b_in_s = i_b;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [W-1:0]         a_seg_s;
        logic [W-1:0]         b_seg_s;
        logic                 c_in_s;
        logic                 v_in_s;
        logic [W:0]           seg_s;
        logic [(k+1)*W-1:0]   s_d;
        logic [(k+1)*W-1:0]   s_q;
        logic                 c_q;
        logic                 v_q;

        if (k == 0) begin : g_head
            assign a_seg_s = i_a[W-1:0];
            assign b_seg_s = b_in_s[W-1:0];
            assign c_in_s  = i_carry_in;
            assign v_in_s  = i_valid;
            assign s_d     = seg_s[W-1:0];
        end else begin : g_body
            // Lowest bits of the forwarded operands are this stage's segment.
            assign a_seg_s = g_stage[k-1].g_fwd.a_q[W-1:0];
            assign b_seg_s = g_stage[k-1].g_fwd.b_q[W-1:0];
            assign c_in_s  = g_stage[k-1].c_q;
            assign v_in_s  = g_stage[k-1].v_q;
            assign s_d     = {seg_s[W-1:0], g_stage[k-1].s_q};
        end

        assign seg_s = {1'b0, a_seg_s} + {1'b0, b_seg_s} + {{W{1'b0}}, c_in_s};

        // Stage register: partial sum, segment carry and valid bit move on advance.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv_s) begin
                v_q <= v_in_s;
                c_q <= seg_s[W];
                s_q <= s_d;
            end else begin
                v_q <= v_q;
                c_q <= c_q;
                s_q <= s_q;
            end
        end

        // Only operand bits not yet added are carried into later stages.
        if (k < STAGES - 1) begin : g_fwd
            localparam int R = N - (k + 1) * W;
            logic [R-1:0] a_d;
            logic [R-1:0] b_d;
            logic [R-1:0] a_q;
            logic [R-1:0] b_q;

            if (k == 0) begin : g_from_port
                assign a_d = i_a[N-1:W];
                assign b_d = b_in_s[N-1:W];
            end else begin : g_from_prev
                assign a_d = g_stage[k-1].g_fwd.a_q[N-k*W-1:W];
                assign b_d = g_stage[k-1].g_fwd.b_q[N-k*W-1:W];
            end

            // Remaining-operand register, frozen with the rest of the pipe.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv_s) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end else begin
                    a_q <= a_q;
                    b_q <= b_q;
                end
            end
        end
    end

    // Output rank: presents the completed sum and holds it while downstream stalls.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid_q     <= 1'b0;
            o_c_q         <= '0;
            o_carry_out_q <= 1'b0;
        end else if (adv_s) begin
            o_valid_q     <= g_stage[STAGES-1].v_q;
            o_c_q         <= g_stage[STAGES-1].s_q;
            o_carry_out_q <= g_stage[STAGES-1].c_q;
        end else begin
            o_valid_q     <= o_valid_q;
            o_c_q         <= o_c_q;
            o_carry_out_q <= o_carry_out_q;
        end
    end

    assign o_valid     = o_valid_q;
    assign o_c         = o_c_q;
    assign o_carry_out = o_carry_out_q;

endmodule
